// File: rtl/enc_pkg.sv
// Shared types and widths for the priority-encoder scan block.
package enc_pkg;
  localparam int VEC_W  = 8;
  localparam int CODE_W = 3;
  localparam int CNT_W  = 16;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;
endpackage

// File: rtl/pri_find8.sv
// Combinational search for the lowest or highest set bit of an 8-bit vector,
// plus a flag that is high when exactly one bit is set.
module pri_find8
  import enc_pkg::*;
(
  input  logic [VEC_W-1:0]  vec,
  input  logic              lsb_first,
  output logic [CODE_W-1:0] idx,
  output logic              single
);

  always_comb begin
    idx = '0;
    // Scan away from the preferred end so the preferred bit is written last.
    if (lsb_first) begin
      for (int i = VEC_W - 1; i >= 0; i--) begin
        if (vec[i]) idx = CODE_W'(i);
      end
    end else begin
      for (int i = 0; i < VEC_W; i++) begin
        if (vec[i]) idx = CODE_W'(i);
      end
    end
    single = (vec != '0) && ((vec & (vec - VEC_W'(1))) == '0);
  end

endmodule

// File: rtl/priority_enc_scan.sv
// Accepts a request vector and emits the index of each set bit, one per
// output handshake, in LSB-first or MSB-first order.
//   state | meaning
//   IDLE  | ready for a new vector, no output
//   SCAN  | emitting codes from the pending register
module priority_enc_scan
  import enc_pkg::*;
#(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [VEC_W-1:0]  in_vec,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CODE_W-1:0] out_code,
  output logic              out_last,
  output logic              zero_err,
  output logic [CNT_W-1:0]  code_cnt
);

  state_t              state;
  logic [VEC_W-1:0]    pending;
  logic [CODE_W-1:0]   sel;
  logic                single;

  pri_find8 u_find (
    .vec       (pending),
    .lsb_first (LSB_FIRST),
    .idx       (sel),
    .single    (single)
  );

  // Handshake strobes are masked during reset so nothing is offered or taken.
  assign in_ready  = (state == IDLE) && !rst;
  assign out_valid = (state == SCAN) && !rst;
  assign out_code  = sel;
  assign out_last  = (state == SCAN) && single;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      pending  <= '0;
      code_cnt <= '0;
      zero_err <= 1'b0;
    end else begin
      zero_err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            if (in_vec == '0) begin
              zero_err <= 1'b1;
            end else begin
              pending <= in_vec;
              state   <= SCAN;
            end
          end
        end
        SCAN: begin
          if (out_ready) begin
            code_cnt <= code_cnt + CNT_W'(1);
            if (single) begin
              pending <= '0;
              state   <= IDLE;
            end else begin
              pending[sel] <= 1'b0;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_priority_enc_scan.sv
// Bench for priority_enc_scan: one LSB-first and one MSB-first instance share
// stimulus; expected codes are queued at send time and popped per handshake.
module tb_priority_enc_scan;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] in_vec = 8'h00;

  logic       in_ready_l, out_valid_l, out_last_l, zero_err_l;
  logic [2:0] out_code_l;
  logic [15:0] code_cnt_l;
  logic       in_ready_m, out_valid_m, out_last_m, zero_err_m;
  logic [2:0] out_code_m;
  logic [15:0] code_cnt_m;

  always #5 clk = ~clk;

  priority_enc_scan #(.LSB_FIRST(1'b1)) dut_l (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_l),
    .in_vec(in_vec), .out_valid(out_valid_l), .out_ready(out_ready),
    .out_code(out_code_l), .out_last(out_last_l), .zero_err(zero_err_l),
    .code_cnt(code_cnt_l)
  );

  priority_enc_scan #(.LSB_FIRST(1'b0)) dut_m (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_m),
    .in_vec(in_vec), .out_valid(out_valid_m), .out_ready(out_ready),
    .out_code(out_code_m), .out_last(out_last_m), .zero_err(zero_err_m),
    .code_cnt(code_cnt_m)
  );

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;
  bit rnd = 1'b0;
  logic [3:0] q_l[$];
  logic [3:0] q_m[$];

  typedef struct {
    logic [7:0] vec;
    int         n;
    logic [2:0] lc[8];
    logic [2:0] mc[8];
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  function automatic void push_model(input logic [7:0] v);
    int n;
    int k;
    n = $countones(v);
    k = 0;
    for (int i = 0; i < 8; i++) begin
      if (v[i]) begin
        k++;
        q_l.push_back({(k == n), 3'(i)});
      end
    end
    k = 0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) begin
        k++;
        q_m.push_back({(k == n), 3'(i)});
      end
    end
  endfunction

  function automatic void push_tbl(input vec_t t);
    for (int i = 0; i < t.n; i++) begin
      q_l.push_back({(i == t.n - 1), t.lc[i]});
      q_m.push_back({(i == t.n - 1), t.mc[i]});
    end
  endfunction

  // Called at posedge+1; returns at posedge+1 of the cycle after acceptance.
  task automatic send(input logic [7:0] v);
    int b = 0;
    while (!in_ready_l && b < 300) begin
      if (rnd) out_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      b++;
    end
    if (!in_ready_l) fail_now("send_timeout");
    in_valid = 1'b1;
    in_vec   = v;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_vec   = 8'($urandom);
  endtask

  task automatic drain();
    int b = 0;
    while ((q_l.size() != 0 || !in_ready_l) && b < 600) begin
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk); #1;
      b++;
    end
    if (q_l.size() != 0 || !in_ready_l) fail_now("drain_timeout");
  endtask

  // Output monitor / scoreboard, sampled mid-cycle.
  initial begin
    logic [3:0] e;
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("rst_in_ready", 32'(in_ready_l), 32'd0);
        chk("rst_out_valid", 32'(out_valid_l), 32'd0);
        q_l.delete();
        q_m.delete();
        exp_cnt = 0;
      end else begin
        chk("code_cnt_l", 32'(code_cnt_l), 32'(exp_cnt));
        chk("code_cnt_m", 32'(code_cnt_m), 32'(exp_cnt));
        if (out_valid_l && out_ready) begin
          if (q_l.size() == 0) fail_now("unexpected_code_l");
          else begin
            e = q_l.pop_front();
            chk("code_l", 32'(out_code_l), 32'(e[2:0]));
            chk("last_l", 32'(out_last_l), 32'(e[3]));
          end
          exp_cnt++;
        end
        if (out_valid_m && out_ready) begin
          if (q_m.size() == 0) fail_now("unexpected_code_m");
          else begin
            e = q_m.pop_front();
            chk("code_m", 32'(out_code_m), 32'(e[2:0]));
            chk("last_m", 32'(out_last_m), 32'(e[3]));
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] v;
    tbl[0] = '{vec: 8'h20, n: 1, lc: '{3'd5, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0},
               mc: '{3'd5, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0}};
    tbl[1] = '{vec: 8'h85, n: 3, lc: '{3'd0, 3'd2, 3'd7, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0},
               mc: '{3'd7, 3'd2, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0}};
    tbl[2] = '{vec: 8'h81, n: 2, lc: '{3'd0, 3'd7, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0},
               mc: '{3'd7, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0}};
    tbl[3] = '{vec: 8'h01, n: 1, lc: '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0},
               mc: '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0}};
    tbl[4] = '{vec: 8'h80, n: 1, lc: '{3'd7, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0},
               mc: '{3'd7, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0}};
    tbl[5] = '{vec: 8'hFF, n: 8, lc: '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7},
               mc: '{3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0}};
    tbl[6] = '{vec: 8'h3C, n: 4, lc: '{3'd2, 3'd3, 3'd4, 3'd5, 3'd0, 3'd0, 3'd0, 3'd0},
               mc: '{3'd5, 3'd4, 3'd3, 3'd2, 3'd0, 3'd0, 3'd0, 3'd0}};
    tbl[7] = '{vec: 8'h03, n: 2, lc: '{3'd0, 3'd1, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0},
               mc: '{3'd1, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0}};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hold_in_ready", 32'(in_ready_l), 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 32'(in_ready_l), 32'd1);
    chk("post_rst_out_valid", 32'(out_valid_l), 32'd0);
    chk("post_rst_code_cnt", 32'(code_cnt_l), 32'd0);
    chk("post_rst_zero_err", 32'(zero_err_l), 32'd0);

    // One-hot: latency and in_ready turnaround
    out_ready = 1'b1;
    @(posedge clk); #1;
    push_tbl(tbl[0]);
    send(tbl[0].vec);
    chk("onehot_in_ready_busy", 32'(in_ready_l), 32'd0);
    chk("onehot_out_valid", 32'(out_valid_l), 32'd1);
    chk("onehot_out_last", 32'(out_last_l), 32'd1);
    @(posedge clk); #1;
    chk("onehot_in_ready_back", 32'(in_ready_l), 32'd1);
    chk("onehot_code_cnt", 32'(code_cnt_l), 32'd1);

    // Table-driven vectors, both scan directions
    for (int t = 0; t < 7; t++) begin
      push_tbl(tbl[t]);
      send(tbl[t].vec);
      drain();
    end

    // Backpressure with in_vec churn during SCAN
    out_ready = 1'b0;
    push_tbl(tbl[7]);
    send(tbl[7].vec);
    for (int c = 0; c < 4; c++) begin
      in_valid = 1'b1;
      in_vec   = 8'hF0;
      chk("bp_valid", 32'(out_valid_l), 32'd1);
      chk("bp_code_l", 32'(out_code_l), 32'd0);
      chk("bp_last_l", 32'(out_last_l), 32'd0);
      chk("bp_code_m", 32'(out_code_m), 32'd1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    drain();

    // Zero vector
    send(8'h00);
    chk("zero_err_l", 32'(zero_err_l), 32'd1);
    chk("zero_err_m", 32'(zero_err_m), 32'd1);
    chk("zero_out_valid", 32'(out_valid_l), 32'd0);
    chk("zero_in_ready", 32'(in_ready_l), 32'd1);
    @(posedge clk); #1;
    chk("zero_err_pulse_end", 32'(zero_err_l), 32'd0);
    chk("zero_out_valid2", 32'(out_valid_l), 32'd0);

    // Reset mid-SCAN after two codes
    out_ready = 1'b1;
    push_model(8'hFF);
    send(8'hFF);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("midscan_code_l", 32'(out_code_l), 32'd2);
    chk("midscan_code_m", 32'(out_code_m), 32'd5);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midscan_rst_valid", 32'(out_valid_l), 32'd0);
    chk("midscan_rst_cnt", 32'(code_cnt_l), 32'd0);
    chk("midscan_rst_in_ready", 32'(in_ready_l), 32'd0);
    rst = 1'b0;
    #1;
    chk("after_rst_in_ready", 32'(in_ready_l), 32'd1);
    chk("after_rst_valid", 32'(out_valid_l), 32'd0);
    repeat (5) @(posedge clk);
    #1;

    // Random vectors with random backpressure
    rnd = 1'b1;
    for (int r = 0; r < 25; r++) begin
      v = 8'($urandom_range(1, 255));
      push_model(v);
      send(v);
    end
    drain();
    rnd = 1'b0;
    drain();
    repeat (3) @(posedge clk);
    #1;
    chk("sb_empty_l", 32'(q_l.size()), 32'd0);
    chk("sb_empty_m", 32'(q_m.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/priority_enc_scan.md
PRIORITY_ENC_SCAN -- requirements
Module: priority_enc_scan

Interface
REQ-001 Parameter: LSB_FIRST, default 1; 1 = emit codes from bit 0 upward, 0 = from bit 7 downward.
REQ-002 clk  input  1  single clock; all state SHALL update on the rising edge only.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_valid  input  1  upstream offers in_vec this cycle.
REQ-005 in_ready  output  1  block can accept a vector this cycle.
REQ-006 in_vec  input  8  one-hot or multi-hot request vector.
REQ-007 out_valid  output  1  out_code is valid this cycle.
REQ-008 out_ready  input  1  downstream accepts out_code this cycle.
REQ-009 out_code  output  3  binary index of the currently selected set bit.
REQ-010 out_last  output  1  high with out_valid when out_code is the final code for the current vector.
REQ-011 zero_err  output  1  one-cycle pulse: an all-zero vector was accepted.
REQ-012 code_cnt  output  16  running count of completed output handshakes.

Function
REQ-013 The FSM SHALL have exactly two states: IDLE and SCAN.
REQ-014 IDLE: in_ready=1, out_valid=0; SCAN: in_ready=0, out_valid=1.
REQ-015 Input handshake = in_valid&&in_ready; on it in IDLE with in_vec!=0, pending<=in_vec and state<=SCAN.
REQ-016 Input handshake with in_vec==0: state stays IDLE, zero_err=1 for exactly the next cycle, no output produced.
REQ-017 Latency: vector accepted at edge N -> out_valid=1 in the cycle following edge N.
REQ-018 In SCAN, out_code = index of lowest set bit of pending (LSB_FIRST=1) or highest set bit (LSB_FIRST=0).
REQ-019 out_last=1 iff pending has exactly one bit set.
REQ-020 Output handshake = out_valid&&out_ready; on it the selected bit SHALL clear in pending and code_cnt SHALL increment by 1.
REQ-021 Handshake with out_last=1: state<=IDLE, pending<=0; in_ready=1 the next cycle.
REQ-022 out_valid=1 and out_ready=0: out_code, out_last and pending SHALL hold unchanged (no drop, no skip).
REQ-023 in_valid and in_vec are ignored while in SCAN; in_vec changes during SCAN have no effect.
REQ-024 code_cnt SHALL wrap 0xFFFF -> 0x0000 without flag.
REQ-025 All outputs SHALL derive from registers/state only; no combinational path from in_vec or out_ready to any output.
REQ-026 Throughput: a vector with k set bits occupies k output cycles plus 1 IDLE cycle minimum.

Reset
REQ-027 While rst=1 at an edge: state<=IDLE, pending<=0, code_cnt<=0, zero_err<=0.
REQ-028 During any cycle with rst=1, in_ready=0 and out_valid=0.
REQ-029 Reset mid-SCAN SHALL discard remaining pending bits; no further codes for that vector are emitted.

Structure
REQ-030 Shared package enc_pkg SHALL hold the state typedef (IDLE, SCAN) and constants VEC_W=8, CODE_W=3, CNT_W=16.
REQ-031 One sub-module pri_find8 SHALL be used: combinational, 8-bit vector plus direction in, 3-bit index and single-bit flag out.
REQ-032 priority_enc_scan SHALL contain the FSM, pending register, counter and handshake logic.

Verification
REQ-033 One-hot: in_vec=8'b0010_0000, out_ready=1 -> one code 3'd5 with out_last=1; code_cnt=1; in_ready=1 two cycles after accept.
REQ-034 Multi-hot LSB_FIRST=1: in_vec=8'b1000_0101, out_ready=1 -> codes 0,2,7 on consecutive cycles; out_last only on 7; code_cnt=3.
REQ-035 LSB_FIRST=0: same vector -> codes 7,2,0; out_last only on 0.
REQ-036 Backpressure: in_vec=8'b0000_0011, out_ready=0 for 4 cycles -> code 0 held 4 cycles, then codes 0,1 after out_ready=1; in_vec change during SCAN ignored.
REQ-037 Zero vector: in_vec=0 accepted -> zero_err=1 for one cycle, out_valid stays 0, code_cnt unchanged.
REQ-038 Reset mid-SCAN: in_vec=8'hFF, rst=1 after 2 codes -> out_valid=0, code_cnt=0, in_ready=1 first cycle after rst=0.
